// File: rtl/morse_receiver_pkg.sv
// morse_receiver_pkg: letter patterns, codes and FSM states shared by the Morse receiver
package morse_receiver_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_SAMPLE, S_DECODE} state_t;

    // Index is the 3-bit letter code (0=I .. 7=P); MSB is the first unit on air.
    localparam logic [7:0][FRAME_BITS-1:0] PATTERNS = {
        16'hBBA0, 16'hEEE0, 16'hE800, 16'hEE00,
        16'hBA80, 16'hEB80, 16'hBBB8, 16'hA000
    };

    // Returns {hit, code}; hit=0 when the frame matches no letter.
    function automatic logic [3:0] decode_frame(input logic [FRAME_BITS-1:0] f);
        decode_frame = 4'b0;
        for (int i = 0; i < 8; i++)
            if (f == PATTERNS[i]) decode_frame = {1'b1, 3'(i)};
    endfunction

endpackage

// File: rtl/morse_sync.sv
// morse_sync: two-flop synchronizer with rise detector for the asynchronous Morse line
module morse_sync (
    input  logic clock,
    input  logic reset,
    input  logic morse_in,
    output logic sync,
    output logic rise
);

    logic meta, prev;
    logic [1:0] fill;

    // prev is held high until the pipeline holds real samples, so a line
    // that is already high at reset release is never seen as a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b1;
            fill <= 2'b0;
        end else begin
            meta <= morse_in;
            sync <= meta;
            fill <= {fill[0], 1'b1};
            prev <= fill[1] ? sync : 1'b1;
        end
    end

    assign rise = fill[1] & sync & ~prev;

endmodule

// File: rtl/morse_receiver.sv
// morse_receiver: mid-unit sampler and 16-unit frame decoder for letters I..P
module morse_receiver
    import morse_receiver_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] HALF = CW'(UNIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(UNIT_CYCLES - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [FRAME_BITS-1:0] frame, frame_nx;
    logic [4:0] bit_cnt, bit_cnt_nx;
    logic [2:0] letter_nx;
    logic valid_nx, error_nx, sync, rise, tick;
    logic [3:0] hit;

    morse_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .morse_in(morse_in),
        .sync    (sync),
        .rise    (rise)
    );

    assign tick = (cnt == '0);
    assign hit  = decode_frame(frame);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        frame_nx   = frame;
        bit_cnt_nx = bit_cnt;
        letter_nx  = letter;
        valid_nx   = 1'b0;
        error_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    cnt_nx   = HALF;
                    state_nx = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (!tick) cnt_nx = cnt - 1'b1;
                else if (!sync) state_nx = S_IDLE;
                else begin
                    frame_nx   = FRAME_BITS'(1);
                    bit_cnt_nx = 5'd1;
                    cnt_nx     = FULL;
                    state_nx   = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (!tick) cnt_nx = cnt - 1'b1;
                else begin
                    frame_nx   = {frame[FRAME_BITS-2:0], sync};
                    bit_cnt_nx = bit_cnt + 5'd1;
                    cnt_nx     = FULL;
                    state_nx   = (bit_cnt == 5'(FRAME_BITS - 1)) ? S_DECODE : S_SAMPLE;
                end
            end
            S_DECODE: begin
                state_nx  = S_IDLE;
                valid_nx  = hit[3];
                error_nx  = ~hit[3];
                letter_nx = hit[3] ? hit[2:0] : letter;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            frame   <= '0;
            bit_cnt <= 5'd0;
            letter  <= 3'd0;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            frame   <= frame_nx;
            bit_cnt <= bit_cnt_nx;
            letter  <= letter_nx;
            valid   <= valid_nx;
            error   <= error_nx;
        end
    end

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: directed frames against morse_receiver with 8 cycles per unit
module tb_morse_receiver;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic morse_in = 1'b0;
    logic [2:0] letter;
    logic valid, error, busy;

    int nvec = 0, nerr = 0;
    int vcnt = 0, ecnt = 0, cyc = 0, first_valid = -1, t0 = 0;
    int last_letter = 0;
    logic [15:0] pats [7] = '{16'hBBB8, 16'hEB80, 16'hBA80, 16'hEE00, 16'hE800, 16'hEEE0, 16'hBBA0};

    morse_receiver #(.UNIT_CYCLES(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .morse_in(morse_in),
        .letter  (letter),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (valid) begin
            vcnt++;
            last_letter = int'(letter);
            if (first_valid < 0) first_valid = cyc;
        end
        if (error) ecnt++;
        if (valid | error) check("valid_error_exclusive", int'(valid & error), 0);
    end

    task automatic send(input logic [15:0] f);
        for (int i = 15; i >= 0; i--) begin
            morse_in = f[i];
            repeat (8) @(negedge clock);
        end
    endtask

    task automatic low(input int units);
        morse_in = 1'b0;
        repeat (8 * units) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_letter", int'(letter), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_error", int'(error), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        t0 = cyc;
        send(16'hA000);
        low(2);
        check("I_count", vcnt, 1);
        check("I_letter", last_letter, 0);
        check("I_noerr", ecnt, 0);
        check("I_latency", int'(first_valid - t0 >= 125 && first_valid - t0 <= 131), 1);

        for (int i = 0; i < 7; i++) begin
            send(pats[i]);
            low(1);
            check("JP_count", vcnt, 2 + i);
            check("JP_letter", last_letter, 1 + i);
        end

        send(16'hFFFF);
        low(2);
        check("bad_error", ecnt, 1);
        check("bad_novalid", vcnt, 8);
        check("bad_letter_held", int'(letter), 7);

        morse_in = 1'b1;
        repeat (2) @(negedge clock);
        morse_in = 1'b0;
        @(negedge clock);
        check("glitch_busy", int'(busy), 1);
        repeat (8) @(negedge clock);
        check("glitch_idle", int'(busy), 0);
        check("glitch_novalid", vcnt, 8);
        check("glitch_noerr", ecnt, 1);
        send(16'hEE00);
        low(2);
        check("M_count", vcnt, 9);
        check("M_letter", last_letter, 4);

        for (int i = 15; i >= 7; i--) begin
            morse_in = (i >= 13 || (i <= 11 && i >= 9) || i == 7);
            repeat (8) @(negedge clock);
        end
        morse_in = 1'b1;
        repeat (4) @(negedge clock);
        check("O_busy_mid", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_letter", int'(letter), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_error", int'(error), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("abort_idle", int'(busy), 0);
        check("abort_nopulse", vcnt + ecnt, 10);
        low(2);
        send(16'hEEE0);
        low(2);
        check("O_count", vcnt, 10);
        check("O_letter", last_letter, 6);

        morse_in = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("high_release_idle", int'(busy), 0);
        check("high_release_nopulse", vcnt + ecnt, 11);
        low(1);
        send(16'hBA80);
        low(2);
        check("L_count", vcnt, 11);
        check("L_letter", int'(letter), 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
